alu_stream: RTL and testbench
=============================

Name: alu_stream

Overview:
- Byte-stream packet ALU placed between the UART receiver and UART transmitter, replacing the single-byte loopback ALU.
- Parses a header of opcode, reserved byte and 16-bit total length.
- Executes echo, add or multiply over little-endian operands, plus divide when enabled.
- Streams results back with valid/ready on both sides.

Parameters:
- WORD_BYTES, 4, operand/result width in bytes (operand width = 8*WORD_BYTES).
- OP_ECHO, 8'hEC, echo payload opcode.
- OP_ADD, 8'hAD, wrapping sum of operands.
- OP_MUL, 8'h63, wrapping product of operands (low 8*WORD_BYTES bits).
- OP_DIV, 8'hD1, unsigned quotient chain (only with ALU_DIV_EN).

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous active-high reset.
- data_i  input  8  inbound byte.
- valid_i  input  1  inbound byte valid.
- ready_o  output  1  block can accept inbound byte.
- data_o  output  8  outbound byte.
- valid_o  output  1  outbound byte valid.
- ready_i  input  1  downstream accepts outbound byte.

Behaviour:
- One clock, clk_i; reset is rst_i, synchronous, active-high. A transfer occurs on a rising edge with valid&ready high on that side.
- Reset: state=HDR_OP, valid_o=0, data_o=0, ready_o=0, accumulator/counters=0. Asserting rst_i mid-packet aborts it; no partial output follows. ready_o=1 the cycle after rst_i deasserts.
- Packet: byte0 opcode, byte1 reserved (ignored), byte2 LEN[7:0], byte3 LEN[15:8]. LEN counts all bytes including the header. Payload = max(LEN-4,0) bytes; LEN<4 means empty payload.
- States:
  - HDR_OP -> HDR_RSV -> LEN_LO -> LEN_HI, one accepted byte each.
  - From LEN_HI:
    - empty payload: ECHO and unknown opcodes go to HDR_OP; arithmetic goes to SEND.
    - else: ECHO goes to ECHO; ADD/MUL/DIV go to COLLECT; unknown opcode goes to DRAIN.
  - ECHO: 1-byte buffer. Accepted byte appears on data_o with valid_o the next cycle. ready_o=0 while the buffer is full. After the last payload byte is sent, return to HDR_OP.
  - COLLECT: assemble operands LSB-first.
    - First complete operand loads the accumulator.
    - Each later one applies the op: ADD single cycle; MUL registered single cycle; DIV enters DIVIDE with ready_o=0.
    - Trailing partial operand bytes (payload not a multiple of WORD_BYTES) are accepted and discarded.
    - After the last payload byte (and any op in flight), go to SEND.
  - SEND: WORD_BYTES bytes of the accumulator, LSB first. data_o stays stable while valid_o=1 and ready_i=0. ready_o=0 throughout. After the last handshake, return to HDR_OP.
  - DRAIN: accept and discard payload bytes; valid_o stays 0; return to HDR_OP.
- Arithmetic with no complete operand sends 0. With exactly one operand, that operand is sent unchanged.
- All arithmetic is unsigned and wraps modulo 2^(8*WORD_BYTES).
- Payload byte counter is 16 bits; LEN=16'hFFFF is legal (65531-byte payload).
- ready_o is never asserted in SEND or DIVIDE. valid_o is only asserted in ECHO and SEND.

Optional Feature:
- ALU_DIV_EN defined:
  - OP_DIV is recognised. Each new operand divides the accumulator through an iterative restoring divider, one quotient bit per cycle, 8*WORD_BYTES cycles.
  - Division by zero yields all-ones.
- ALU_DIV_EN undefined: OP_DIV is an unknown opcode (DRAIN, no output) and no divider logic is present.

Test Plan:
- Echo: EC 00 06 00 05 E7 -> output 05 E7, then idle; ready_o low exactly while the echo buffer is full.
- Add with wrap: AD 00 0C 00 FF FF FF FF 02 00 00 00 -> 01 00 00 00; with LEN=0E and 2 extra bytes AA BB -> same result, extras discarded.
- Multiply: 63 00 10 00 07 00 00 00 06 00 00 00 02 00 00 00 -> 54 00 00 00.
- Unknown opcode and empty add:
  - 55 00 07 00 11 22 33 -> no output.
  - Then AD 00 04 00 -> 00 00 00 00.
  - Then echo of 2A -> 2A.
- Backpressure/reset: hold ready_i=0 for 10 cycles during SEND -> data_o/valid_o stable, no byte lost. Pulse rst_i mid-COLLECT -> valid_o=0, next packet processed correctly.
- Divide (ALU_DIV_EN): D1 00 0C 00 64 00 00 00 07 00 00 00 -> 0E 00 00 00; divisor 0 -> FF FF FF FF. Without the macro, the same packet produces no output.

Source files
------------

// File: rtl/alu_stream.sv
// Byte-stream packet ALU: parses an opcode/reserved/length header and then echoes, adds or multiplies
// little-endian operands. The divide opcode and its iterative divider exist only when ALU_DIV_EN is defined.
module alu_stream #(
    parameter int         WORD_BYTES = 4,
    parameter logic [7:0] OP_ECHO    = 8'hEC,
    parameter logic [7:0] OP_ADD     = 8'hAD,
    parameter logic [7:0] OP_MUL     = 8'h63
`ifdef ALU_DIV_EN
    ,
    parameter logic [7:0] OP_DIV     = 8'hD1
`endif
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i
);

    localparam int W     = 8 * WORD_BYTES;
    localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(WORD_BYTES - 1);

    typedef enum logic [3:0] {
        S_HDR_OP,
        S_HDR_RSV,
        S_LEN_LO,
        S_LEN_HI,
        S_ECHO,
        S_COLLECT,
        S_DIVIDE,
        S_SEND,
        S_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       op_q, op_d;
    logic [7:0]       len_lo_q, len_lo_d;
    logic [7:0]       echo_q, echo_d;
    logic             echo_full_q, echo_full_d;
    logic             have_acc_q, have_acc_d;
    logic [15:0]      rem_q, rem_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [W-1:0]     opnd_q, opnd_d;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [IDX_W-1:0] send_idx_q, send_idx_d;

    logic [W-1:0]     word_in;
    logic [15:0]      pkt_len;
    logic [15:0]      payload_len;
    logic             op_arith;
    logic             in_fire;
    logic             out_fire;

`ifdef ALU_DIV_EN
    localparam int DCNT_W = $clog2(W);

    logic [W-1:0]      div_q, div_d;
    logic [W-1:0]      div_rem_q, div_rem_d;
    logic [DCNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [W:0]        div_shift;
    logic [W-1:0]      div_diff;

    assign div_shift = {div_rem_q, acc_q[W-1]};
    assign div_diff  = div_shift[W-1:0] - div_q;
    assign op_arith  = (op_q == OP_ADD) || (op_q == OP_MUL) || (op_q == OP_DIV);
`else
    assign op_arith  = (op_q == OP_ADD) || (op_q == OP_MUL);
`endif

    // The incoming byte is merged into its lane so a completing byte is usable in the same cycle.
    genvar gi;
    generate
        for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
            assign word_in[gi*8 +: 8] = (byte_idx_q == IDX_W'(gi)) ? data_i : opnd_q[gi*8 +: 8];
        end
    endgenerate

    assign pkt_len     = {data_i, len_lo_q};
    assign payload_len = (pkt_len > 16'd4) ? (pkt_len - 16'd4) : 16'd0;

    always_comb begin
        ready_o = 1'b0;
        if (!rst_i) begin
            case (state_q)
                S_HDR_OP, S_HDR_RSV, S_LEN_LO, S_LEN_HI, S_COLLECT, S_DRAIN: ready_o = 1'b1;
                S_ECHO:  ready_o = !echo_full_q;
                default: ready_o = 1'b0;
            endcase
        end
    end

    assign valid_o  = (state_q == S_SEND) || ((state_q == S_ECHO) && echo_full_q);
    assign data_o   = (state_q == S_SEND) ? acc_q[7:0] : echo_q;
    assign in_fire  = valid_i && ready_o;
    assign out_fire = valid_o && ready_i;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        len_lo_d    = len_lo_q;
        echo_d      = echo_q;
        echo_full_d = echo_full_q;
        have_acc_d  = have_acc_q;
        rem_d       = rem_q;
        acc_d       = acc_q;
        opnd_d      = opnd_q;
        byte_idx_d  = byte_idx_q;
        send_idx_d  = send_idx_q;
`ifdef ALU_DIV_EN
        div_d       = div_q;
        div_rem_d   = div_rem_q;
        div_cnt_d   = div_cnt_q;
`endif

        case (state_q)
            S_HDR_OP: if (in_fire) begin
                op_d    = data_i;
                state_d = S_HDR_RSV;
            end
            S_HDR_RSV: if (in_fire) state_d = S_LEN_LO;
            S_LEN_LO: if (in_fire) begin
                len_lo_d = data_i;
                state_d  = S_LEN_HI;
            end
            S_LEN_HI: if (in_fire) begin
                rem_d       = payload_len;
                acc_d       = '0;
                have_acc_d  = 1'b0;
                byte_idx_d  = '0;
                send_idx_d  = '0;
                echo_full_d = 1'b0;
                if (payload_len == 16'd0)
                    state_d = op_arith ? S_SEND : S_HDR_OP;
                else if (op_q == OP_ECHO)
                    state_d = S_ECHO;
                else if (op_arith)
                    state_d = S_COLLECT;
                else
                    state_d = S_DRAIN;
            end
            S_ECHO: begin
                // ready_o is low while full, so accept and send never coincide.
                if (in_fire) begin
                    echo_d      = data_i;
                    echo_full_d = 1'b1;
                    rem_d       = rem_q - 16'd1;
                end else if (out_fire) begin
                    echo_full_d = 1'b0;
                    if (rem_q == 16'd0) state_d = S_HDR_OP;
                end
            end
            S_COLLECT: if (in_fire) begin
                rem_d      = rem_q - 16'd1;
                opnd_d     = word_in;
                byte_idx_d = (byte_idx_q == LAST_LANE) ? '0 : byte_idx_q + IDX_W'(1);
                if (rem_q == 16'd1) state_d = S_SEND;
                if (byte_idx_q == LAST_LANE) begin
                    if (!have_acc_q) begin
                        acc_d      = word_in;
                        have_acc_d = 1'b1;
                    end else if (op_q == OP_ADD) begin
                        acc_d = acc_q + word_in;
                    end else if (op_q == OP_MUL) begin
                        acc_d = acc_q * word_in;
                    end
`ifdef ALU_DIV_EN
                    else begin
                        div_d     = word_in;
                        div_rem_d = '0;
                        div_cnt_d = '0;
                        state_d   = S_DIVIDE;
                    end
`endif
                end
            end
`ifdef ALU_DIV_EN
            S_DIVIDE: begin
                // Restoring step: the dividend shifts out of acc_q while quotient bits shift in.
                if (div_shift >= {1'b0, div_q}) begin
                    div_rem_d = div_diff;
                    acc_d     = {acc_q[W-2:0], 1'b1};
                end else begin
                    div_rem_d = div_shift[W-1:0];
                    acc_d     = {acc_q[W-2:0], 1'b0};
                end
                div_cnt_d = div_cnt_q + DCNT_W'(1);
                if (div_cnt_q == DCNT_W'(W - 1))
                    state_d = (rem_q == 16'd0) ? S_SEND : S_COLLECT;
            end
`endif
            S_SEND: if (out_fire) begin
                acc_d      = acc_q >> 8;
                send_idx_d = send_idx_q + IDX_W'(1);
                if (send_idx_q == LAST_LANE) state_d = S_HDR_OP;
            end
            S_DRAIN: if (in_fire) begin
                rem_d = rem_q - 16'd1;
                if (rem_q == 16'd1) state_d = S_HDR_OP;
            end
            default: state_d = S_HDR_OP;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_HDR_OP;
            op_q        <= '0;
            len_lo_q    <= '0;
            echo_q      <= '0;
            echo_full_q <= 1'b0;
            have_acc_q  <= 1'b0;
            rem_q       <= '0;
            acc_q       <= '0;
            opnd_q      <= '0;
            byte_idx_q  <= '0;
            send_idx_q  <= '0;
`ifdef ALU_DIV_EN
            div_q       <= '0;
            div_rem_q   <= '0;
            div_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            len_lo_q    <= len_lo_d;
            echo_q      <= echo_d;
            echo_full_q <= echo_full_d;
            have_acc_q  <= have_acc_d;
            rem_q       <= rem_d;
            acc_q       <= acc_d;
            opnd_q      <= opnd_d;
            byte_idx_q  <= byte_idx_d;
            send_idx_q  <= send_idx_d;
`ifdef ALU_DIV_EN
            div_q       <= div_d;
            div_rem_q   <= div_rem_d;
            div_cnt_q   <= div_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_stream.sv
// Self-checking bench for alu_stream: expected output bytes are queued as packets are driven and
// compared against bytes captured from the output handshake.
module tb_alu_stream;

    logic       clk     = 1'b0;
    logic       rst_i   = 1'b1;
    logic [7:0] data_i  = 8'h00;
    logic       valid_i = 1'b0;
    logic       ready_i = 1'b1;
    logic       ready_o;
    logic [7:0] data_o;
    logic       valid_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] tx_q[$];

    always #5 clk = ~clk;

    alu_stream dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    // Inputs change only 1ns after posedge, so the mid-cycle view predicts the next edge's handshake.
    always @(negedge clk) begin
        if (!rst_i && valid_o && ready_i) got_q.push_back(data_o);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_byte(input logic [7:0] b);
        int n;
        n       = 0;
        data_i  = b;
        valid_i = 1'b1;
        @(negedge clk);
        while (!ready_o && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) begin
            total_cnt++;
            $display("FAIL drive_timeout: ready_o=%0b required 1 for byte %02h", ready_o, b);
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic send_pkt();
        $display("pkt op=%02h bytes=%0d", tx_q[0], tx_q.size());
        while (tx_q.size() > 0) drive_byte(tx_q.pop_front());
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick(3);
        total_cnt++;
        if (valid_o !== 1'b0) $display("FAIL reset_valid: got %0b required 0", valid_o);
        else pass_cnt++;
        total_cnt++;
        if (data_o !== 8'h00) $display("FAIL reset_data: got %02h required 00", data_o);
        else pass_cnt++;
        total_cnt++;
        if (ready_o !== 1'b0) $display("FAIL reset_ready: got %0b required 0", ready_o);
        else pass_cnt++;
        rst_i = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (ready_o !== 1'b1) $display("FAIL reset_release_ready: got %0b required 1", ready_o);
        else pass_cnt++;
        tick(1);
    endtask

    task automatic test_echo();
        logic [7:0] e, g;
        logic       stable;
        ready_i = 1'b0;
        tx_q = '{8'hEC, 8'h00, 8'h06, 8'h00};
        send_pkt();
        exp_q.push_back(8'h05);
        drive_byte(8'h05);
        total_cnt++;
        if (valid_o !== 1'b1 || data_o !== 8'h05 || ready_o !== 1'b0)
            $display("FAIL echo_full: valid=%0b data=%02h ready=%0b required 1/05/0", valid_o, data_o, ready_o);
        else pass_cnt++;
        stable = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (ready_o !== 1'b0 || valid_o !== 1'b1) stable = 1'b0;
        end
        total_cnt++;
        if (!stable) $display("FAIL echo_hold: ready_o/valid_o changed while buffer full, required 0/1");
        else pass_cnt++;
        tick(1);
        ready_i = 1'b1;
        tick(1);
        total_cnt++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1)
            $display("FAIL echo_empty: valid=%0b ready=%0b required 0/1", valid_o, ready_o);
        else pass_cnt++;
        exp_q.push_back(8'hE7);
        drive_byte(8'hE7);
        tick(6);
        total_cnt++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1)
            $display("FAIL echo_idle: valid=%0b ready=%0b required 0/1", valid_o, ready_o);
        else pass_cnt++;
        $display("out echo: %0d bytes", got_q.size());
        total_cnt++;
        if (got_q.size() != exp_q.size())
            $display("FAIL echo_count: got %0d bytes required %0d", got_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            total_cnt++;
            if (g !== e) $display("FAIL echo_byte: got %02h required %02h", g, e);
            else pass_cnt++;
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_add();
        logic [7:0] e, g;
        exp_q.push_back(8'h01); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        tx_q = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
        send_pkt();
        tick(10);
        exp_q.push_back(8'h01); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        tx_q = '{8'hAD, 8'h00, 8'h0E, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00,
                 8'hAA, 8'hBB};
        send_pkt();
        tick(10);
        exp_q.push_back(8'h78); exp_q.push_back(8'h56); exp_q.push_back(8'h34); exp_q.push_back(8'h12);
        tx_q = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        send_pkt();
        tick(10);
        $display("out add: %0d bytes", got_q.size());
        total_cnt++;
        if (got_q.size() != exp_q.size())
            $display("FAIL add_count: got %0d bytes required %0d", got_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            total_cnt++;
            if (g !== e) $display("FAIL add_byte: got %02h required %02h", g, e);
            else pass_cnt++;
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_mul();
        logic [7:0] e, g;
        exp_q.push_back(8'h54); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        tx_q = '{8'h63, 8'h00, 8'h10, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'h06, 8'h00, 8'h00, 8'h00,
                 8'h02, 8'h00, 8'h00, 8'h00};
        send_pkt();
        tick(10);
        $display("out mul: %0d bytes", got_q.size());
        total_cnt++;
        if (got_q.size() != exp_q.size())
            $display("FAIL mul_count: got %0d bytes required %0d", got_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            total_cnt++;
            if (g !== e) $display("FAIL mul_byte: got %02h required %02h", g, e);
            else pass_cnt++;
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [7:0] e, g;
        // Unknown opcode, empty adds (LEN=4 and LEN=2), empty echo, then a one-byte echo, all back to back.
        tx_q = '{8'h55, 8'h00, 8'h07, 8'h00, 8'h11, 8'h22, 8'h33};
        send_pkt();
        exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        tx_q = '{8'hAD, 8'h00, 8'h04, 8'h00};
        send_pkt();
        exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        tx_q = '{8'hAD, 8'h00, 8'h02, 8'h00};
        send_pkt();
        tx_q = '{8'hEC, 8'h00, 8'h04, 8'h00};
        send_pkt();
        exp_q.push_back(8'h2A);
        tx_q = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h2A};
        send_pkt();
        tick(10);
        $display("out back_to_back: %0d bytes", got_q.size());
        total_cnt++;
        if (got_q.size() != exp_q.size())
            $display("FAIL b2b_count: got %0d bytes required %0d", got_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            total_cnt++;
            if (g !== e) $display("FAIL b2b_byte: got %02h required %02h", g, e);
            else pass_cnt++;
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_backpressure();
        logic [7:0] e, g;
        logic       stable;
        ready_i = 1'b0;
        exp_q.push_back(8'h45); exp_q.push_back(8'h34); exp_q.push_back(8'h23); exp_q.push_back(8'h12);
        tx_q = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h01, 8'h01, 8'h01, 8'h01};
        send_pkt();
        total_cnt++;
        if (valid_o !== 1'b1 || data_o !== 8'h45 || ready_o !== 1'b0)
            $display("FAIL bp_first: valid=%0b data=%02h ready=%0b required 1/45/0", valid_o, data_o, ready_o);
        else pass_cnt++;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (valid_o !== 1'b1 || data_o !== 8'h45 || ready_o !== 1'b0) stable = 1'b0;
        end
        total_cnt++;
        if (!stable) $display("FAIL bp_stable: outputs moved during stall, required valid=1 data=45 ready=0");
        else pass_cnt++;
        tick(1);
        ready_i = 1'b1;
        tick(10);
        $display("out backpressure: %0d bytes", got_q.size());
        total_cnt++;
        if (got_q.size() != exp_q.size())
            $display("FAIL bp_count: got %0d bytes required %0d", got_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            total_cnt++;
            if (g !== e) $display("FAIL bp_byte: got %02h required %02h", g, e);
            else pass_cnt++;
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [7:0] e, g;
        tx_q = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02};
        send_pkt();
        rst_i = 1'b1;
        tick(2);
        total_cnt++;
        if (valid_o !== 1'b0 || ready_o !== 1'b0)
            $display("FAIL mid_reset: valid=%0b ready=%0b required 0/0", valid_o, ready_o);
        else pass_cnt++;
        rst_i = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (ready_o !== 1'b1) $display("FAIL mid_reset_ready: got %0b required 1", ready_o);
        else pass_cnt++;
        tick(10);
        exp_q.push_back(8'h54); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        tx_q = '{8'h63, 8'h00, 8'h10, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'h06, 8'h00, 8'h00, 8'h00,
                 8'h02, 8'h00, 8'h00, 8'h00};
        send_pkt();
        tick(10);
        $display("out reset_mid: %0d bytes", got_q.size());
        total_cnt++;
        if (got_q.size() != exp_q.size())
            $display("FAIL rst_count: got %0d bytes required %0d", got_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            total_cnt++;
            if (g !== e) $display("FAIL rst_byte: got %02h required %02h", g, e);
            else pass_cnt++;
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_div();
        logic [7:0] e, g;
`ifdef ALU_DIV_EN
        exp_q.push_back(8'h0E); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF); exp_q.push_back(8'hFF); exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
`endif
        tx_q = '{8'hD1, 8'h00, 8'h0C, 8'h00, 8'h64, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        send_pkt();
        tick(60);
        tx_q = '{8'hD1, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_pkt();
        tick(60);
        $display("out div: %0d bytes", got_q.size());
        total_cnt++;
        if (got_q.size() != exp_q.size())
            $display("FAIL div_count: got %0d bytes required %0d", got_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            total_cnt++;
            if (g !== e) $display("FAIL div_byte: got %02h required %02h", g, e);
            else pass_cnt++;
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        test_reset();
        test_echo();
        test_add();
        test_mul();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_div();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
